// File: rtl/vram_arbiter.sv
// vram_arbiter: video/CPU arbiter for a single-port synchronous VRAM, video has priority.
// Define VRAM_ARB_STARVE_EN to force a CPU grant after MAX_WAIT consecutive blocked cycles.
module vram_arbiter #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [12:0] vid_addr,
  output logic [7:0]  vid_data,
  output logic        vid_valid,
  output logic        vid_drop,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUED, ACK} state_t;
  state_t      state_q, state_d;
  logic        rd_q, rd_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        vid_p1_q, vid_p1_d;
  logic        vid_valid_q, vid_valid_d;
  logic [7:0]  vid_data_q, vid_data_d;
  logic        cpu_idle, force_cpu, grant_cpu, grant_vid;

`ifdef VRAM_ARB_STARVE_EN
  logic [4:0] wait_q, wait_d;
  logic       drop_p1_q, drop_p1_d, vid_drop_q, vid_drop_d;
  assign force_cpu = cpu_idle && cpu_req && vid_req && wait_q == 5'(MAX_WAIT);
  always_comb begin
    wait_d = (grant_cpu || !cpu_req) ? 5'd0 :
             (cpu_idle && vid_req && wait_q != 5'd31) ? wait_q + 5'd1 : wait_q;
    drop_p1_d = force_cpu;
    vid_drop_d = drop_p1_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
      drop_p1_q <= 1'b0;
      vid_drop_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      drop_p1_q <= drop_p1_d;
      vid_drop_q <= vid_drop_d;
    end
  end
  assign vid_drop = vid_drop_q;
`else
  assign force_cpu = 1'b0;
  assign vid_drop = 1'b0;
`endif

  assign cpu_idle = state_q == IDLE;
  assign grant_cpu = cpu_idle && cpu_req && (!vid_req || force_cpu);
  assign grant_vid = vid_req && !force_cpu;
  // With no grant the RAM still sees vid_addr so the port stays deterministic.
  assign ram_addr = grant_cpu ? cpu_addr : vid_addr;
  assign ram_we = grant_cpu && cpu_we;
  assign ram_wdata = cpu_wdata;

  always_comb begin
    state_d = grant_cpu ? ISSUED : (state_q == ISSUED) ? ACK : IDLE;
    rd_d = grant_cpu ? !cpu_we : rd_q;
    cpu_ack_d = state_q == ISSUED;
    cpu_rdata_d = (state_q == ISSUED && rd_q) ? ram_rdata : cpu_rdata_q;
    vid_p1_d = grant_vid;
    vid_valid_d = vid_p1_q;
    vid_data_d = vid_p1_q ? ram_rdata : vid_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      cpu_rdata_q <= '0;
      vid_p1_q <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      cpu_ack_q <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_p1_q <= vid_p1_d;
      vid_valid_q <= vid_valid_d;
      vid_data_q <= vid_data_d;
    end
  end

  assign cpu_ack = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_valid = vid_valid_q;
  assign vid_data = vid_data_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: random video/CPU traffic against a cycle-indexed expectation model of the arbiter.
module tb_vram_arbiter;
  localparam int MW = 16;
  localparam int NC = 2400;
  localparam int R1 = 600;
  localparam int R2 = 1700;
`ifdef VRAM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [12:0] vid_addr = '0, cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic [7:0] vid_data, cpu_rdata, ram_wdata, ram_rdata;
  logic vid_valid, vid_drop, cpu_ack, ram_we;
  logic [12:0] ram_addr;

  vram_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid), .vid_drop(vid_drop),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [8192];
  logic [7:0] shadow [8192];
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs indexed by the cycle in which they must appear.
  bit ev_vv [NC+4];
  bit ev_drop [NC+4];
  bit ev_ack [NC+4];
  bit ev_rd [NC+4];
  logic [7:0] ev_vd [NC+4];
  logic [7:0] ev_rdv [NC+4];
  int cpu_idle_at = 0, wcnt = 0;
  logic [7:0] exp_rdata = '0;
  bit idle, frc, gv, gc;

  function automatic logic [12:0] pick_addr();
    return (($urandom % 2) != 0 ? 13'h1FF0 : 13'h0000) | 13'($urandom % 16);
  endfunction

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem[i] = 8'(i * 7 + 3);
      shadow[i] = 8'(i * 7 + 3);
    end
    for (int i = 0; i < NC + 4; i++) begin
      ev_vv[i] = 0; ev_drop[i] = 0; ev_ack[i] = 0; ev_rd[i] = 0;
      ev_vd[i] = '0; ev_rdv[i] = '0;
    end
    #1;
    check("rst_vid_valid", vid_valid, 0);
    check("rst_vid_data", vid_data, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_vid_drop", vid_drop, 0);
    repeat (2) @(posedge clk);
    for (int c = 0; c < NC; c++) begin
      @(posedge clk); #1;
      if (reset) reset = 1'b0;
      check("vid_valid", vid_valid, ev_vv[c]);
      if (ev_vv[c]) check("vid_data", vid_data, ev_vd[c]);
      check("cpu_ack", cpu_ack, ev_ack[c]);
      check("vid_drop", vid_drop, ev_drop[c]);
      if (ev_rd[c]) exp_rdata = ev_rdv[c];
      check("cpu_rdata", cpu_rdata, exp_rdata);
      if (c == R1 + 1 || c == R2 + 1) begin
        reset = 1'b1; #1;
        check("arst_cpu_ack", cpu_ack, 0);
        check("arst_cpu_rdata", cpu_rdata, 0);
        check("arst_vid_valid", vid_valid, 0);
        check("arst_vid_data", vid_data, 0);
        check("arst_vid_drop", vid_drop, 0);
        for (int k = c + 1; k < c + 4; k++) begin
          ev_vv[k] = 0; ev_drop[k] = 0; ev_ack[k] = 0; ev_rd[k] = 0;
        end
        exp_rdata = '0;
        cpu_idle_at = 0;
        wcnt = 0;
        continue;
      end
      if (c >= 1000 && c < 1300) begin
        vid_req = 1'b1;
        cpu_req = 1'b1;
      end else if (c < 1000) begin
        vid_req = ($urandom % 2) != 0;
        cpu_req = ($urandom % 2) != 0;
      end else begin
        vid_req = ($urandom % 4) == 0;
        cpu_req = ($urandom % 4) != 0;
      end
      cpu_we = ($urandom % 2) != 0;
      cpu_addr = pick_addr();
      vid_addr = pick_addr();
      cpu_wdata = 8'($urandom);
      // Quiet CPU before each reset point so a read is granted right before reset hits.
      if ((c >= R1 - 3 && c < R1) || (c >= R2 - 3 && c < R2)) cpu_req = 1'b0;
      if (c == R1 || c == R2) begin
        vid_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0;
      end
      #1;
      idle = c >= cpu_idle_at;
      frc = STARVE && idle && cpu_req && vid_req && wcnt == MW;
      gv = vid_req && !frc;
      gc = idle && cpu_req && (!vid_req || frc);
      check("ram_we", ram_we, gc && cpu_we);
      check("ram_addr", ram_addr, gc ? cpu_addr : vid_addr);
      if (gc && cpu_we) check("ram_wdata", ram_wdata, cpu_wdata);
      if (gv) begin
        ev_vv[c+2] = 1;
        ev_vd[c+2] = shadow[vid_addr];
      end
      if (frc) ev_drop[c+2] = 1;
      if (gc) begin
        ev_ack[c+2] = 1;
        cpu_idle_at = c + 3;
        if (cpu_we) shadow[cpu_addr] = cpu_wdata;
        else begin
          ev_rd[c+2] = 1;
          ev_rdv[c+2] = shadow[cpu_addr];
        end
      end
      if (STARVE) begin
        if (gc || !cpu_req) wcnt = 0;
        else if (idle && vid_req && wcnt < 31) wcnt++;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
